// File: rtl/vga_sync_gen_if.sv
// Purpose: timing bundle produced by vga_sync_gen and consumed by the pattern stages.
// Signals:
//   hcnt, vcnt   pixel / line position (10-bit)
//   hsync, vsync registered sync levels
//   video_on     visible-area flag
//   pix_tick     one-clock pixel enable
//   frame_start  one-clock pulse when the position becomes (0,0)
// Modports: master drives the bundle, slave observes it.
interface vga_sync_gen_if;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       pix_tick;
  logic       frame_start;

  modport master (
    output hcnt, vcnt, hsync, vsync, video_on, pix_tick, frame_start
  );

  modport slave (
    input hcnt, vcnt, hsync, vsync, video_on, pix_tick, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Purpose: VGA timing generator. Divides clk to a pixel enable, runs the
// horizontal/vertical counters and produces registered sync, video_on and
// frame_start aligned with the counters.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   sync_o  timing bundle (vga_sync_gen_if.master)
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vga_sync_gen_if.master        sync_o
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC - 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             pix_tick_q, pix_tick_d;
  logic             frame_start_q, frame_start_d;
  logic             tick_c;

  // Pixel enable: the edge on which the divider wraps advances the counters.
  assign tick_c = (div_q == DIV_W'(CLK_DIV - 1));

  // Next-state counters; the flags below decode these so they line up with hcnt/vcnt.
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick_c) begin
      div_d = '0;
      if (hcnt_q == CNT_W'(H_TOTAL - 1)) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : vcnt_q + CNT_W'(1);
      end else begin
        hcnt_d = hcnt_q + CNT_W'(1);
      end
    end
  end

  // Output decode from the next position.
  always_comb begin
    hsync_d       = ~SYNC_POL;
    vsync_d       = ~SYNC_POL;
    video_on_d    = 1'b0;
    pix_tick_d    = tick_c;
    frame_start_d = 1'b0;
    if ((hcnt_d >= CNT_W'(HS_BEG)) && (hcnt_d <= CNT_W'(HS_END))) hsync_d = SYNC_POL;
    if ((vcnt_d >= CNT_W'(VS_BEG)) && (vcnt_d <= CNT_W'(VS_END))) vsync_d = SYNC_POL;
    if ((hcnt_d < CNT_W'(H_ACTIVE)) && (vcnt_d < CNT_W'(V_ACTIVE))) video_on_d = 1'b1;
    if (tick_c && (hcnt_d == '0) && (vcnt_d == '0)) frame_start_d = 1'b1;
  end

  // State and output registers; reset parks the position in blanking at (H_TOTAL-1, V_TOTAL-1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      hcnt_q        <= CNT_W'(H_TOTAL - 1);
      vcnt_q        <= CNT_W'(V_TOTAL - 1);
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pix_tick_q    <= pix_tick_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sync_o.hcnt        = hcnt_q;
  assign sync_o.vcnt        = vcnt_q;
  assign sync_o.hsync       = hsync_q;
  assign sync_o.vsync       = vsync_q;
  assign sync_o.video_on    = video_on_q;
  assign sync_o.pix_tick    = pix_tick_q;
  assign sync_o.frame_start = frame_start_q;

endmodule
